seq_detector: RTL and testbench

Parametrised Moore-style serial pattern detector, the successor to the fixed four-bit "1001" detector. Samples one bit per enabled clock, compares the most recent N bits against a runtime-loadable pattern, and reports matches as a one-cycle pulse or a sticky flag. Supports overlapping or non-overlapping detection and keeps a saturating match counter. Sits on serial bit streams, for example frame-sync or marker detection in front of a deserialiser.

---
 rtl/seq_detector.sv | 128 ++++++++++++
 tb/tb_seq_detector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// seq_detector
//   Parametrised serial pattern detector. One bit of i_data is taken on each
//   rising edge of i_clk where i_enable is high. The most recent N sampled bits
//   are compared against a runtime-loadable pattern (MSB = oldest bit), and each
//   match is reported on a registered output. The output is either a one-cycle
//   pulse or a sticky flag. A saturating counter records the number of matches.
//
// Parameters
//   N        pattern length in bits (2..32)
//   PATTERN  reset value of the pattern register, MSB received first
//   OVERLAP  1: matches may share bits; 0: search restarts after a match
//   STICKY   1: o_out holds after a match until clear/load/reset
//   CNT_W    width of the match counter
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       sample i_data on this edge
//   i_data         serial input bit
//   i_clear        synchronous clear of search state, o_out and o_match_count
//   i_pat_load     synchronous load of i_pat_in into the pattern register
//   i_pat_in       new pattern, MSB first
//   o_out          registered match indication
//   o_match_count  matches since reset/clear, saturating at all-ones

module seq_detector #(
    parameter int unsigned  N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1001,
    parameter bit           OVERLAP = 1'b1,
    parameter bit           STICKY  = 1'b0,
    parameter int unsigned  CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_data,
    input  logic             i_clear,
    input  logic             i_pat_load,
    input  logic [N-1:0]     i_pat_in,
    output logic             o_out,
    output logic [CNT_W-1:0] o_match_count
);

    localparam int unsigned      FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [N-1:0]     r_pat;
    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    logic [N-1:0]     w_pat_nxt;
    logic [N-1:0]     w_hist_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic             w_out_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_restart;
    logic [N-1:0]     w_hist_shift;
    logic [FW-1:0]    w_fill_inc;
    logic             w_match;

    // clear and pat_load both throw away the current search and this edge's bit
    assign w_restart    = i_clear | i_pat_load;
    assign w_hist_shift = {r_hist[N-2:0], i_data};
    assign w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FW'(1);

    // Only a full window of valid bits may match, so stale zeros in the
    // history after a restart can never produce a false hit.
    assign w_match = i_enable & ~w_restart
                   & (w_fill_inc == FILL_FULL)
                   & (w_hist_shift == r_pat);

    always_comb begin
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_cnt_nxt  = r_cnt;
        // pulse mode drops o_out on every edge that does not complete a match,
        // including edges with i_enable low
        w_out_nxt  = STICKY ? r_out : 1'b0;

        if (i_pat_load) begin
            w_pat_nxt = i_pat_in;
        end

        if (w_restart) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
            w_out_nxt  = 1'b0;
            if (i_clear) begin
                w_cnt_nxt = '0;
            end
        end else if (i_enable) begin
            w_hist_nxt = w_hist_shift;
            // without overlap the next match needs N completely fresh bits
            w_fill_nxt = (w_match && !OVERLAP) ? '0 : w_fill_inc;
            if (w_match) begin
                w_out_nxt = 1'b1;
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_out  <= w_out_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_out         = r_out;
    assign o_match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector.sv
// Testbench for seq_detector: four instances with different parameter sets,
// each driven separately, checked every cycle against a bit-list model plus
// hand-computed expectations.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en  [4];
    logic       dat [4];
    logic       clr [4];
    logic       ld  [4];
    logic [3:0] pin [4];

    logic       o0, o1, o2, o3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: defaults   1: no overlap   2: sticky   3: pattern 1111, 2-bit counter
    seq_detector u_dut0 (.i_clk(clk), .i_reset(reset), .i_enable(en[0]), .i_data(dat[0]),
        .i_clear(clr[0]), .i_pat_load(ld[0]), .i_pat_in(pin[0]), .o_out(o0), .o_match_count(c0));
    seq_detector #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .STICKY(1'b0), .CNT_W(8)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_enable(en[1]), .i_data(dat[1]),
        .i_clear(clr[1]), .i_pat_load(ld[1]), .i_pat_in(pin[1]), .o_out(o1), .o_match_count(c1));
    seq_detector #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .STICKY(1'b1), .CNT_W(8)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_enable(en[2]), .i_data(dat[2]),
        .i_clear(clr[2]), .i_pat_load(ld[2]), .i_pat_in(pin[2]), .o_out(o2), .o_match_count(c2));
    seq_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .STICKY(1'b0), .CNT_W(2)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .i_enable(en[3]), .i_data(dat[3]),
        .i_clear(clr[3]), .i_pat_load(ld[3]), .i_pat_in(pin[3]), .o_out(o3), .o_match_count(c3));

    // ---------------- model: list of bits received since last restart ----------------
    bit         ov [4] = '{1, 0, 1, 1};
    bit         st [4] = '{0, 0, 1, 0};
    int         mx [4] = '{255, 255, 255, 3};
    logic [3:0] rp [4] = '{4'b1001, 4'b1001, 4'b1001, 4'b1111};

    int         m_len [4];
    bit         m_buf [4][64];
    logic [3:0] m_pat [4];
    int         m_cnt [4];
    bit         m_out [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_len[i] = 0;
            m_pat[i] = rp[i];
            m_cnt[i] = 0;
            m_out[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit match;
        match = 1'b0;
        if (clr[i] || ld[i]) begin
            m_len[i] = 0;
            m_out[i] = 1'b0;
            if (clr[i]) m_cnt[i] = 0;
            if (ld[i])  m_pat[i] = pin[i];
        end else if (en[i]) begin
            m_buf[i][m_len[i] % 64] = dat[i];
            m_len[i]++;
            if (m_len[i] >= 4) begin
                match = 1'b1;
                // pattern bit k (LSB = newest) against the k-th most recent sample
                for (int k = 0; k < 4; k++)
                    if (m_buf[i][(m_len[i] - 1 - k) % 64] != m_pat[i][k]) match = 1'b0;
            end
            if (match) begin
                if (m_cnt[i] < mx[i]) m_cnt[i]++;
                if (!ov[i]) m_len[i] = 0;
            end
            m_out[i] = st[i] ? (m_out[i] | match) : match;
        end else if (!st[i]) begin
            m_out[i] = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else for (int i = 0; i < 4; i++) model_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("out0", 32'(o0), 32'(m_out[0]));
                chk("out1", 32'(o1), 32'(m_out[1]));
                chk("out2", 32'(o2), 32'(m_out[2]));
                chk("out3", 32'(o3), 32'(m_out[3]));
                chk("cnt0", 32'(c0), 32'(m_cnt[0]));
                chk("cnt1", 32'(c1), 32'(m_cnt[1]));
                chk("cnt2", 32'(c2), 32'(m_cnt[2]));
                chk("cnt3", 32'(c3), 32'(m_cnt[3]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int i, input bit e, input bit d, input bit c, input bit l,
                        input logic [3:0] p);
        @(negedge clk);
        en[i] = e; dat[i] = d; clr[i] = c; ld[i] = l; pin[i] = p;
        @(posedge clk);
        #1;
        en[i] = 1'b0; dat[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0; pin[i] = 4'b0;
    endtask

    task automatic send(input int i, input bit d);
        step(i, 1'b1, d, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic idle(input int i);
        step(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic send_bits(input int i, input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) send(i, bits[k]);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0; dat[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0; pin[i] = 4'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out0", 32'(o0), 0);
        chk("rst_out2", 32'(o2), 0);
        chk("rst_cnt0", 32'(c0), 0);
        chk("rst_cnt3", 32'(c3), 0);

        // defaults, 0,1,0,0,1
        send_bits(0, 16'b0100, 4);
        chk("t1_before", 32'(o0), 0);
        send(0, 1'b1);
        chk("t1_out", 32'(o0), 1);
        chk("t1_cnt", 32'(c0), 1);
        idle(0);
        chk("t1_pulse_end", 32'(o0), 0);

        // overlap with pattern 1010 (clear + load together)
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
        chk("t2_clr_cnt", 32'(c0), 0);
        send_bits(0, 16'b1010, 4);
        chk("t2_ov_first", 32'(o0), 1);
        send(0, 1'b1);
        chk("t2_ov_gap", 32'(o0), 0);
        send(0, 1'b0);
        chk("t2_ov_second", 32'(o0), 1);
        chk("t2_ov_cnt", 32'(c0), 2);
        step(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
        send_bits(1, 16'b101010, 6);
        chk("t2_nov_out", 32'(o1), 0);
        chk("t2_nov_cnt", 32'(c1), 1);

        // sticky
        send_bits(2, 16'b1001, 4);
        chk("t3_rise", 32'(o2), 1);
        send_bits(2, 16'b000, 3);
        chk("t3_hold", 32'(o2), 1);
        chk("t3_cnt", 32'(c2), 1);
        step(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0);
        chk("t3_clr_out", 32'(o2), 0);
        chk("t3_clr_cnt", 32'(c2), 0);

        // pattern load mid-stream (1,0,0 adds one more 1010 overlap hit first)
        send_bits(0, 16'b100, 3);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        chk("t4_load_cnt", 32'(c0), 3);
        chk("t4_load_out", 32'(o0), 0);
        send(0, 1'b1);
        chk("t4_no_match", 32'(o0), 0);
        send_bits(0, 16'b0110, 4);
        chk("t4_match", 32'(o0), 1);
        chk("t4_cnt", 32'(c0), 4);

        // saturation with 2-bit counter, then enable gaps
        send_bits(3, 16'b1111, 4);
        chk("t5_first", 32'(o3), 1);
        chk("t5_cnt1", 32'(c3), 1);
        send_bits(3, 16'b111, 3);
        chk("t5_last", 32'(o3), 1);
        chk("t5_sat", 32'(c3), 3);
        step(3, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0);
        send(3, 1'b1);
        send(3, 1'b1);
        repeat (3) idle(3);
        send(3, 1'b1);
        chk("t5_gap_partial", 32'(o3), 0);
        idle(3);
        send(3, 1'b1);
        chk("t5_gap_match", 32'(o3), 1);
        chk("t5_gap_cnt", 32'(c3), 1);
        idle(3);

        // async reset while sticky out is high, with a loaded pattern
        step(2, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        send_bits(2, 16'b0110, 4);
        chk("t6_pre_out", 32'(o2), 1);
        chk("t6_pre_cnt", 32'(c2), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_out", 32'(o2), 0);
        chk("t6_async_cnt", 32'(c2), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        send_bits(2, 16'b1001, 4);
        chk("t6_pat_restored", 32'(o2), 1);
        chk("t6_cnt", 32'(c2), 1);

        repeat (2) idle(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
